uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver, the receive-side counterpart of the UART transmitter. Recovers 8N1 frames from
//  the asynchronous serial line using the shared oversampling baud_tick. Delivers each good byte
//  to the RX FIFO / command parser with a one-cycle done strobe, and flags stop-bit errors.
//  Sits between the board RX pin and the UART FIFO.
// PARAMETERS
//  OVERSAMPLE  16  baud_tick pulses per bit period; even, >=4
//  DATA_BITS   8   data bits per frame, LSB first; 1..8
// PORTS
//  clk          in   1          system clock, all flops on rising edge
//  reset        in   1          asynchronous, active-low reset (0 = reset)
//  baud_tick    in   1          1-clk pulse at OVERSAMPLE x baud rate
//  rx           in   1          raw serial line, idle high, asynchronous to clk
//  o_rx_data    out  DATA_BITS  last good byte; held until the next good frame
//  o_rx_done    out  1          1-clk pulse: o_rx_data updated this cycle
//  o_rx_busy    out  1          high while a frame is in progress
//  o_frame_err  out  1          1-clk pulse: stop bit sampled low, frame discarded
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, both sync flops=1, rx_prev=1, counters=0, shift reg=0.
//   o_rx_data=0, o_rx_done=0, o_rx_busy=0, o_frame_err=0. Applies mid-frame: the partial frame is
//   dropped and no done or error pulse is issued.
//  Input: rx goes through a 2-flop synchronizer to give rx_s. rx_prev is rx_s delayed by one clk.
//   All decisions use rx_s only. Pin-to-rx_s latency is 2 clk.
//  Counters: b_cnt (log2 OVERSAMPLE bits) counts baud_ticks; bit_cnt counts 0..DATA_BITS-1.
//   Counters advance only on cycles with baud_tick=1.
//  States:
//  IDLE: busy=0. Start is detected on a falling edge (rx_prev=1 and rx_s=0), independent of baud_tick.
//   On detection: go to START, b_cnt=0, busy=1 on the next clk.
//   A line held low (break) produces no edge, so it never retriggers.
//  START: on each tick, if b_cnt==OVERSAMPLE/2-1 (mid start bit):
//   rx_s=0 -> DATA, b_cnt=0, bit_cnt=0.
//   rx_s=1 -> glitch; go to IDLE, busy=0, no pulse.
//   Otherwise on a tick, b_cnt+1.
//  DATA: on each tick, if b_cnt==OVERSAMPLE-1 (mid data bit): shift rx_s in at the MSB
//   (shift right, so bit 0 ends up LSB) and set b_cnt=0.
//   If bit_cnt==DATA_BITS-1 go to STOP, else bit_cnt+1. Otherwise on a tick, b_cnt+1.
//  STOP: on each tick, if b_cnt==OVERSAMPLE-1 (mid stop bit):
//   rx_s=1 -> o_rx_data<=shift reg, o_rx_done=1 for one clk.
//   rx_s=0 -> o_frame_err=1 for one clk; o_rx_data unchanged.
//   In both cases go to IDLE; busy falls on the same clk edge as the pulse rises.
//  Outputs: all are registered. done and err are never high together and never high longer than 1 clk.
//  Back-to-back frames: a new start edge is accepted in the IDLE cycle right after STOP.
//   This gives about half a bit of margin, so a stop bit of 1.0 bit is sufficient.
//  baud_tick and start-edge in the same cycle: the edge is taken and the tick is ignored (b_cnt=0).
//  Latency: o_rx_done rises (2 + 1 + (OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE) ticks) after the start edge,
//   i.e. about 9.5 bit periods.
// TESTING (bench: 100 MHz clk, baud_tick every 4 clk -> 1 bit = 64 clk at OVERSAMPLE=16)
//  1 Send 0xA5 with a valid stop -> exactly one o_rx_done pulse, o_rx_data=8'hA5, o_frame_err stays 0,
//    busy=0 afterwards.
//  2 Send 0x00 then 0xFF back-to-back with a 1-bit stop -> two done pulses, data 0x00 then 0xFF,
//    no error.
//  3 Send 0x3C with stop bit forced low -> o_frame_err pulse, no done, o_rx_data keeps the previous value.
//    Then hold rx low for 20 bits -> no new frame.
//    Then release rx high and send 0x81 -> done pulse with data 0x81.
//  4 Low glitch of 3 ticks on idle rx -> no done, no error; busy returns to 0 within 8 ticks.
//  5 Assert reset mid-DATA of 0x5A, release, then send 0x96 -> no pulse for 0x5A;
//    all outputs 0 during reset; done with data 0x96.
//  6 Send 0x55 with the bit period skewed +3% and -3% -> done pulse with 0x55 both times.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with oversampled mid-bit sampling and stop-bit error flag
module uart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_done,
   output logic                 o_rx_busy,
   output logic                 o_frame_err
);

   localparam int BCW = $clog2(OVERSAMPLE);
   localparam int NW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [BCW-1:0] MID_START = BCW'(OVERSAMPLE/2 - 1);
   localparam logic [BCW-1:0] MID_BIT   = BCW'(OVERSAMPLE - 1);
   localparam logic [NW-1:0]  LAST_BIT  = NW'(DATA_BITS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]           state;
   logic                 rx_meta;
   logic                 rx_s;
   logic                 rx_prev;
   logic [BCW-1:0]       b_cnt;
   logic [NW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] shift_next;
   logic                 start_edge;

   assign start_edge = rx_prev & ~rx_s;

   // Right shift with the new bit entering at the MSB, so bit 0 lands at the LSB.
   always_comb begin
      shift_next                = shift_reg >> 1;
      shift_next[DATA_BITS-1]   = rx_s;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         b_cnt       <= '0;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         o_rx_data   <= '0;
         o_rx_done   <= 1'b0;
         o_rx_busy   <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_rx_done   <= 1'b0;
         o_frame_err <= 1'b0;
         case (state)
            IDLE: begin
               // Edge wins over a coincident tick: counting restarts from zero.
               if (start_edge) begin
                  state     <= START;
                  b_cnt     <= '0;
                  o_rx_busy <= 1'b1;
               end
            end
            START: begin
               if (baud_tick) begin
                  if (b_cnt == MID_START) begin
                     b_cnt <= '0;
                     if (!rx_s) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                     end else begin
                        state     <= IDLE;
                        o_rx_busy <= 1'b0;
                     end
                  end else begin
                     b_cnt <= b_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (baud_tick) begin
                  if (b_cnt == MID_BIT) begin
                     b_cnt     <= '0;
                     shift_reg <= shift_next;
                     if (bit_cnt == LAST_BIT) begin
                        state <= STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     b_cnt <= b_cnt + 1'b1;
                  end
               end
            end
            default: begin
               if (baud_tick) begin
                  if (b_cnt == MID_BIT) begin
                     b_cnt     <= '0;
                     state     <= IDLE;
                     o_rx_busy <= 1'b0;
                     if (rx_s) begin
                        o_rx_data <= shift_reg;
                        o_rx_done <= 1'b1;
                     end else begin
                        o_frame_err <= 1'b1;
                     end
                  end else begin
                     b_cnt <= b_cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level reference model
module tb_uart_rx;

   logic       clk;
   logic       reset;
   logic       baud_tick;
   logic       rx;
   logic [7:0] o_rx_data;
   logic       o_rx_done;
   logic       o_rx_busy;
   logic       o_frame_err;

   int n_cmp = 0;
   int n_bad = 0;

   uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .baud_tick   (baud_tick),
      .rx          (rx),
      .o_rx_data   (o_rx_data),
      .o_rx_done   (o_rx_done),
      .o_rx_busy   (o_rx_busy),
      .o_frame_err (o_frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   // Observed events
   logic [7:0] done_q[$];
   int         err_seen     = 0;
   int         overlap_seen = 0;
   int         long_seen    = 0;
   logic       prev_done    = 1'b0;
   logic       prev_err     = 1'b0;

   always @(negedge clk) begin
      if (o_rx_done) done_q.push_back(o_rx_data);
      if (o_frame_err) err_seen++;
      if (o_rx_done && o_frame_err) overlap_seen++;
      if ((o_rx_done && prev_done) || (o_frame_err && prev_err)) long_seen++;
      prev_done = o_rx_done;
      prev_err  = o_frame_err;
   end

   // Reference model: what a correct receiver reports for the frames sent
   logic [7:0] exp_q[$];
   int         exp_err   = 0;
   logic [7:0] last_good = 8'h00;

   task automatic clear_scenario();
      done_q.delete();
      exp_q.delete();
      err_seen = 0;
      exp_err  = 0;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bit_clks);
      rx = 1'b0;
      repeat (bit_clks) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (bit_clks) @(negedge clk);
      end
      rx = stop_ok;
      repeat (bit_clks) @(negedge clk);
      if (stop_ok) begin
         exp_q.push_back(b);
         last_good = b;
      end else begin
         exp_err++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rx    = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++; if (o_rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", o_rx_data); end
      n_cmp++; if (o_rx_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", o_rx_done); end
      n_cmp++; if (o_rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", o_rx_busy); end
      n_cmp++; if (o_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", o_frame_err); end
      reset = 1'b1;
      repeat (70) @(negedge clk);
      last_good = 8'h00;
   endtask

   task automatic test_single();
      clear_scenario();
      send_frame(8'hA5, 1'b1, 64);
      repeat (16) @(negedge clk);
      n_cmp++; if (done_q.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d expected 1", done_q.size()); end
      else begin
         n_cmp++; if (done_q[0] !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h expected a5", done_q[0]); end
      end
      n_cmp++; if (err_seen !== 0) begin n_bad++; $display("FAIL single_err: got %0d expected 0", err_seen); end
      n_cmp++; if (o_rx_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b expected 0", o_rx_busy); end
      n_cmp++; if (o_rx_data !== 8'hA5) begin n_bad++; $display("FAIL single_hold: got %h expected a5", o_rx_data); end
   endtask

   task automatic test_back_to_back();
      clear_scenario();
      send_frame(8'h00, 1'b1, 64);
      send_frame(8'hFF, 1'b1, 64);
      repeat (16) @(negedge clk);
      n_cmp++; if (done_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d expected %0d", done_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++; if (done_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_data%0d: got %h expected %h", i, done_q[i], exp_q[i]); end
      end
      n_cmp++; if (err_seen !== 0) begin n_bad++; $display("FAIL b2b_err: got %0d expected 0", err_seen); end
   endtask

   task automatic test_frame_err();
      clear_scenario();
      send_frame(8'h3C, 1'b0, 64);
      repeat (16) @(negedge clk);
      n_cmp++; if (err_seen !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d expected 1", err_seen); end
      n_cmp++; if (done_q.size() !== 0) begin n_bad++; $display("FAIL ferr_done: got %0d expected 0", done_q.size()); end
      n_cmp++; if (o_rx_data !== last_good) begin n_bad++; $display("FAIL ferr_hold: got %h expected %h", o_rx_data, last_good); end
      // Break: line stays low for 20 bit times
      repeat (20 * 64) @(negedge clk);
      n_cmp++; if (o_rx_busy !== 1'b0) begin n_bad++; $display("FAIL break_busy: got %b expected 0", o_rx_busy); end
      n_cmp++; if (done_q.size() !== 0 || err_seen !== 1) begin n_bad++; $display("FAIL break_events: got done=%0d err=%0d expected done=0 err=1", done_q.size(), err_seen); end
      rx = 1'b1;
      repeat (64) @(negedge clk);
      send_frame(8'h81, 1'b1, 64);
      repeat (16) @(negedge clk);
      n_cmp++; if (done_q.size() !== 1) begin n_bad++; $display("FAIL recover_count: got %0d expected 1", done_q.size()); end
      else begin
         n_cmp++; if (done_q[0] !== 8'h81) begin n_bad++; $display("FAIL recover_data: got %h expected 81", done_q[0]); end
      end
   endtask

   task automatic test_glitch();
      clear_scenario();
      rx = 1'b0;
      repeat (6) @(negedge clk);
      n_cmp++; if (o_rx_busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_rise: got %b expected 1", o_rx_busy); end
      repeat (6) @(negedge clk);
      rx = 1'b1;
      repeat (32) @(negedge clk);
      n_cmp++; if (o_rx_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_fall: got %b expected 0", o_rx_busy); end
      repeat (64) @(negedge clk);
      n_cmp++; if (done_q.size() !== 0 || err_seen !== 0) begin n_bad++; $display("FAIL glitch_events: got done=%0d err=%0d expected 0 0", done_q.size(), err_seen); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      clear_scenario();
      b  = 8'h5A;
      rx = 1'b0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         repeat (64) @(negedge clk);
      end
      reset = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if ({o_rx_data, o_rx_done, o_rx_busy, o_frame_err} !== 11'd0) begin n_bad++; $display("FAIL midreset_outputs: got %h expected 000", {o_rx_data, o_rx_done, o_rx_busy, o_frame_err}); end
      reset     = 1'b1;
      last_good = 8'h00;
      repeat (6 * 64) @(negedge clk);
      n_cmp++; if (done_q.size() !== 0 || err_seen !== 0) begin n_bad++; $display("FAIL midreset_events: got done=%0d err=%0d expected 0 0", done_q.size(), err_seen); end
      send_frame(8'h96, 1'b1, 64);
      repeat (16) @(negedge clk);
      n_cmp++; if (done_q.size() !== 1) begin n_bad++; $display("FAIL after_reset_count: got %0d expected 1", done_q.size()); end
      else begin
         n_cmp++; if (done_q[0] !== 8'h96) begin n_bad++; $display("FAIL after_reset_data: got %h expected 96", done_q[0]); end
      end
   endtask

   task automatic test_skew();
      clear_scenario();
      send_frame(8'h55, 1'b1, 66);
      repeat (64) @(negedge clk);
      send_frame(8'h55, 1'b1, 62);
      repeat (64) @(negedge clk);
      n_cmp++; if (done_q.size() !== 2) begin n_bad++; $display("FAIL skew_count: got %0d expected 2", done_q.size()); end
      else for (int i = 0; i < 2; i++) begin
         n_cmp++; if (done_q[i] !== 8'h55) begin n_bad++; $display("FAIL skew_data%0d: got %h expected 55", i, done_q[i]); end
      end
      n_cmp++; if (err_seen !== 0) begin n_bad++; $display("FAIL skew_err: got %0d expected 0", err_seen); end
   endtask

   task automatic test_random();
      logic [7:0] b;
      bit         ok;
      int         bc;
      clear_scenario();
      for (int k = 0; k < 24; k++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         bc = $urandom_range(63, 65);
         send_frame(b, ok, bc);
         if (!ok) begin
            rx = 1'b1;
            repeat (64) @(negedge clk);
         end else begin
            repeat ($urandom_range(0, 100)) @(negedge clk);
         end
      end
      repeat (16) @(negedge clk);
      n_cmp++; if (done_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d expected %0d", done_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++; if (done_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_data%0d: got %h expected %h", i, done_q[i], exp_q[i]); end
      end
      n_cmp++; if (err_seen !== exp_err) begin n_bad++; $display("FAIL rand_err: got %0d expected %0d", err_seen, exp_err); end
      n_cmp++; if (o_rx_data !== last_good) begin n_bad++; $display("FAIL rand_hold: got %h expected %h", o_rx_data, last_good); end
   endtask

   task automatic test_pulse_shape();
      n_cmp++; if (overlap_seen !== 0) begin n_bad++; $display("FAIL pulse_overlap: got %0d expected 0", overlap_seen); end
      n_cmp++; if (long_seen !== 0) begin n_bad++; $display("FAIL pulse_width: got %0d expected 0", long_seen); end
   endtask

   initial begin
      reset = 1'b0;
      rx    = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_err();
      test_glitch();
      test_reset_mid();
      test_skew();
      test_random();
      test_pulse_shape();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
